// File: rtl/conv_pixel_feeder.sv
// conv_pixel_feeder: streams one IMG_HEIGHT x IMG_WIDTH frame from a synchronous-read frame memory to a conv engine
// Ports: clk/rst_n (async active-low); start+base_addr begin a frame; mem_en/mem_addr/mem_rdata read the
// frame memory (data one cycle after mem_en); out_data/out_valid/out_ready/out_eol/out_last is the pixel
// stream in raster order; busy is high while a frame is in progress; done pulses once after the last pixel.
module conv_pixel_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_HEIGHT = 96,
  parameter int IMG_WIDTH  = 96,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  localparam int TOTAL = IMG_HEIGHT * IMG_WIDTH;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int WW = $clog2(IMG_WIDTH + 1);
  localparam logic [CW-1:0] TOT = CW'(TOTAL);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [WW-1:0] COL_LAST = WW'(IMG_WIDTH - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0] rd_cnt, px_cnt;
  logic [WW-1:0] col_cnt;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic wr_ptr, rd_ptr, rd_pending, push, pop;
  logic [1:0] fifo_count;
  assign busy = state == RUN;
  assign out_valid = fifo_count != 2'd0;
  assign out_data = fifo[rd_ptr];
  assign out_eol = out_valid && col_cnt == COL_LAST;
  assign out_last = out_valid && px_cnt == LAST;
  assign pop = out_valid && out_ready;
  assign push = rd_pending;
  assign mem_addr = base + ADDR_WIDTH'(rd_cnt);
  // Occupancy counts the read in flight, and a same-cycle pop frees a slot, so the FIFO can never overfill.
  assign mem_en = busy && rd_cnt < TOT &&
                  ({1'b0, fifo_count} + {2'b0, rd_pending} < 3'd2 + {2'b0, pop});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      rd_cnt <= '0;
      px_cnt <= '0;
      col_cnt <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rd_pending <= 1'b0;
      fifo_count <= 2'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_pending <= mem_en;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          base <= base_addr;
          rd_cnt <= '0;
          px_cnt <= '0;
          col_cnt <= '0;
          wr_ptr <= 1'b0;
          rd_ptr <= 1'b0;
          fifo_count <= 2'd0;
        end
      end else begin
        if (mem_en) rd_cnt <= rd_cnt + 1'b1;
        if (push) begin
          fifo[wr_ptr] <= mem_rdata;
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
          px_cnt <= px_cnt + 1'b1;
          col_cnt <= out_eol ? '0 : col_cnt + 1'b1;
          if (out_last) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
    end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_count == 2'd2));
endmodule
